// File: rtl/ysyx_23060236_wbu.sv
// ysyx_23060236_wbu: write-back stage. Holds the GPR file, commits LSU results,
// keeps a per-register pending-writer count for RAW stall detection, and counts
// retired instructions.
// Optional feature macro: YSYX_23060236_WBU_BYPASS_EN (forward the committing
// value to the read ports and release rs_busy in the commit cycle).
//
// Handshakes: wb_valid is a one-cycle commit pulse that is always accepted.
// An issue fires only when iss_valid and iss_ready are both high at a posedge.
// iss_ready never depends on iss_valid.
module ysyx_23060236_wbu #(
   parameter int ADDR_WIDTH = 5,
   parameter int PEND_WIDTH = 2,
   parameter int CNT_WIDTH  = 64
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  wb_valid,
   input  logic [31:0]           wb_val,
   input  logic [ADDR_WIDTH-1:0] wb_rd,
   input  logic                  wb_wen,
   input  logic                  iss_valid,
   input  logic [ADDR_WIDTH-1:0] iss_rd,
   input  logic                  iss_wen,
   output logic                  iss_ready,
   input  logic [ADDR_WIDTH-1:0] rs1_addr,
   input  logic [ADDR_WIDTH-1:0] rs2_addr,
   output logic [31:0]           rs1_val,
   output logic [31:0]           rs2_val,
   output logic                  rs_busy,
   output logic                  retire_valid,
   output logic [CNT_WIDTH-1:0]  retire_cnt
);

   localparam int NUM_REGS = 1 << ADDR_WIDTH;
   localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;
   localparam logic [PEND_WIDTH-1:0] PEND_ONE = PEND_WIDTH'(1);

   logic [31:0]           gpr       [NUM_REGS];
   logic [PEND_WIDTH-1:0] pend      [NUM_REGS];
   logic [PEND_WIDTH-1:0] pend_next [NUM_REGS];
   logic                  commit;
   logic                  issue;
   logic                  busy1;
   logic                  busy2;

   // Commit/issue qualifiers; x0 is never written and never tracked.
   always_comb begin
      commit    = wb_valid & wb_wen & (wb_rd != '0);
      iss_ready = ~(iss_wen & (iss_rd != '0) & (pend[iss_rd] == PEND_MAX))
                  | (commit & (wb_rd == iss_rd));
      issue     = iss_valid & iss_ready & iss_wen & (iss_rd != '0);
   end

   // Pending counters: +1 on issue, -1 on commit, unchanged when both hit the
   // same register, and held at 0 on a stray commit instead of wrapping.
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         pend_next[i] = pend[i];
         if (issue && (iss_rd == ADDR_WIDTH'(i)) &&
             !(commit && (wb_rd == ADDR_WIDTH'(i)))) begin
            pend_next[i] = pend[i] + PEND_ONE;
         end else if (commit && (wb_rd == ADDR_WIDTH'(i)) &&
                      !(issue && (iss_rd == ADDR_WIDTH'(i))) &&
                      (pend[i] != '0)) begin
            pend_next[i] = pend[i] - PEND_ONE;
         end
      end
   end

   // Pending counter register.
   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REGS; i++) pend[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) pend[i] <= pend_next[i];
      end
   end

   // GPR file write port.
   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REGS; i++) gpr[i] <= '0;
      end else if (commit) begin
         gpr[wb_rd] <= wb_val;
      end
   end

   // Asynchronous read ports and RAW busy indication.
   always_comb begin
      rs1_val = (rs1_addr == '0) ? 32'h0 : gpr[rs1_addr];
      rs2_val = (rs2_addr == '0) ? 32'h0 : gpr[rs2_addr];
      busy1   = (rs1_addr != '0) && (pend[rs1_addr] != '0);
      busy2   = (rs2_addr != '0) && (pend[rs2_addr] != '0);
`ifdef YSYX_23060236_WBU_BYPASS_EN
      if (commit && (wb_rd == rs1_addr)) begin
         rs1_val = wb_val;
         if (pend[rs1_addr] == PEND_ONE) busy1 = 1'b0;
      end
      if (commit && (wb_rd == rs2_addr)) begin
         rs2_val = wb_val;
         if (pend[rs2_addr] == PEND_ONE) busy2 = 1'b0;
      end
`endif
      rs_busy = busy1 | busy2;
   end

   // Retire pulse and wrapping retired-instruction counter.
   always_ff @(posedge clock) begin
      if (!reset) begin
         retire_valid <= 1'b0;
         retire_cnt   <= '0;
      end else begin
         retire_valid <= wb_valid;
         if (wb_valid) retire_cnt <= retire_cnt + CNT_WIDTH'(1);
      end
   end

   // A commit to a register with no outstanding writer is a protocol error.
   always_ff @(posedge clock) begin
      if (reset && commit) assert (pend[wb_rd] != '0);
   end

endmodule
